// File: rtl/eq2_vector_checker.sv
// Stimulus sequencer for a 2-bit equality comparator: replays stored (a, b, exp)
// vectors, samples aeqb after each dwell period and reports the mismatches.
module eq2_vector_checker #(
    parameter int ADDR_W = 3,
    parameter int N_VEC  = 8,
    parameter int DWELL  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [4:0]        wr_data,
    input  logic              start,
    input  logic              aeqb,
    output logic [1:0]        a,
    output logic [1:0]        b,
    output logic              busy,
    output logic              done_tick,
    output logic              fail,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N_VEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t            state;
    logic [4:0]        mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] next_idx;
    logic [CNT_W-1:0]  cnt;
    logic              exp_bit;

    assign next_idx = idx + ADDR_W'(1);

    // Vector memory keeps its contents across reset; writes are locked out while a pass runs.
    always_ff @(posedge clk) begin
        if (wr_en && state != DRIVE) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            a              <= '0;
            b              <= '0;
            exp_bit        <= 1'b0;
            idx            <= '0;
            cnt            <= '0;
            busy           <= 1'b0;
            done_tick      <= 1'b0;
            fail           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= DRIVE;
                        busy           <= 1'b1;
                        fail           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        idx            <= '0;
                        a              <= mem[0][4:3];
                        b              <= mem[0][2:1];
                        exp_bit        <= mem[0][0];
                        cnt            <= CNT_RELOAD;
                    end
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (aeqb != exp_bit) begin
                            err_cnt <= err_cnt + (ADDR_W + 1)'(1);
                            fail    <= 1'b1;
                            if (err_cnt == '0) begin
                                first_err_addr <= idx;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            idx     <= next_idx;
                            a       <= mem[next_idx][4:3];
                            b       <= mem[next_idx][2:1];
                            exp_bit <= mem[next_idx][0];
                            cnt     <= CNT_RELOAD;
                        end
                    end
                end
                DONE: begin
                    done_tick <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq2_vector_checker.sv
// Scoreboard bench for eq2_vector_checker driving a behavioural eq2 comparator.
module tb_eq2_vector_checker;

    localparam int ADDR_W = 3;
    localparam int N_VEC  = 8;
    localparam int DWELL  = 4;
    localparam int RUN    = N_VEC * DWELL;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [4:0]        wr_data = '0;
    logic              start = 1'b0;
    logic              aeqb;
    logic [1:0]        a, b;
    logic              busy, done_tick, fail;
    logic [ADDR_W:0]   err_cnt;
    logic [ADDR_W-1:0] first_err_addr;

    eq2_vector_checker #(.ADDR_W(ADDR_W), .N_VEC(N_VEC), .DWELL(DWELL)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .aeqb(aeqb), .a(a), .b(b), .busy(busy), .done_tick(done_tick),
        .fail(fail), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
    );

    assign aeqb = (a == b);

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W:0]   errs;
        logic              fl;
        logic [ADDR_W-1:0] first;
        int                lat;
    } res_t;

    res_t       sb[$];
    logic [1:0] ma [N_VEC];
    logic [1:0] mb [N_VEC];
    logic       me [N_VEC];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic write_vec(input int addr, input logic [1:0] va, input logic [1:0] vb, input logic ve);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = {va, vb, ve};
        @(negedge clk);
        wr_en   = 1'b0;
        ma[addr] = va;
        mb[addr] = vb;
        me[addr] = ve;
    endtask

    task automatic run_pass(input bit disturb);
        res_t r;
        res_t got;
        int   lat = -1;
        r.errs  = '0;
        r.fl    = 1'b0;
        r.first = '0;
        r.lat   = RUN + 1;
        for (int i = 0; i < N_VEC; i++) begin
            if ((ma[i] == mb[i]) != me[i]) begin
                if (r.errs == '0) r.first = ADDR_W'(i);
                r.errs = r.errs + 1'b1;
                r.fl   = 1'b1;
            end
        end
        sb.push_back(r);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= RUN + 20; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k < RUN) begin
                check("a_hold", 32'(a), 32'(ma[k / DWELL]));
                check("b_hold", 32'(b), 32'(mb[k / DWELL]));
                check("busy_run", 32'(busy), 32'd1);
            end else if (k == RUN) begin
                check("busy_end", 32'(busy), 32'd0);
                check("a_last", 32'(a), 32'(ma[N_VEC-1]));
            end
            if (disturb && k == 10) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = 5'b11001;
            end
            if (disturb && k == 11) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (done_tick) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
        got = sb.pop_front();
        check("done_latency", 32'(lat), 32'(got.lat));
        check("err_cnt", 32'(err_cnt), 32'(got.errs));
        check("fail", 32'(fail), 32'(got.fl));
        check("first_err_addr", 32'(first_err_addr), 32'(got.first));
        @(posedge clk);
        #1;
        check("done_single", 32'(done_tick), 32'd0);
        check("err_cnt_held", 32'(err_cnt), 32'(got.errs));
    endtask

    task automatic reset_mid_pass(input int at_cycle);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= at_cycle; k++) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_a", 32'(a), 32'd0);
        check("rst_b", 32'(b), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] pa [N_VEC] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
        logic [1:0] pb [N_VEC] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10};

        #12;
        check("rst0_a", 32'(a), 32'd0);
        check("rst0_b", 32'(b), 32'd0);
        check("rst0_busy", 32'(busy), 32'd0);
        check("rst0_done", 32'(done_tick), 32'd0);
        check("rst0_fail", 32'(fail), 32'd0);
        check("rst0_err_cnt", 32'(err_cnt), 32'd0);
        check("rst0_first", 32'(first_err_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < N_VEC; i++) write_vec(i, pa[i], pb[i], pa[i] == pb[i]);
        run_pass(1'b0);

        write_vec(5, pa[5], pb[5], !(pa[5] == pb[5]));
        run_pass(1'b0);

        write_vec(5, pa[5], pb[5], pa[5] == pb[5]);
        write_vec(2, pa[2], pb[2], !(pa[2] == pb[2]));
        write_vec(6, pa[6], pb[6], !(pa[6] == pb[6]));
        run_pass(1'b0);

        write_vec(2, pa[2], pb[2], pa[2] == pb[2]);
        write_vec(6, pa[6], pb[6], pa[6] == pb[6]);
        run_pass(1'b0);

        // Mid-pass start pulse and write to mem[0] must both be ignored.
        run_pass(1'b1);
        run_pass(1'b0);

        reset_mid_pass(10);
        run_pass(1'b0);

        for (int i = 0; i < N_VEC - 1; i++) begin
            logic [1:0] v;
            v = 2'(i);
            write_vec(i, v, ~v, 1'b1);
        end
        write_vec(N_VEC - 1, 2'b10, 2'b10, 1'b1);
        run_pass(1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
